hdr_capture_buffer: RTL and testbench

- Upstream neighbour of the fixed-graph header parser.
- Accepts a packet as a 32-bit big-endian word stream with valid/ready and captures the first HDR_MAX_LEN bytes into a byte-array header buffer.
- Pulses start_o to launch the parser, then holds the buffer stable until the parser reports completion on parser_ready_i.
- Discards payload bytes beyond HDR_MAX_LEN.

---
 rtl/hdr_capture_buffer_pkg.sv | 28 ++
 rtl/hdr_byte_writer.sv | 53 +++++
 rtl/hdr_capture_buffer.sv | 187 ++++++++++++++++++
 tb/tb_hdr_capture_buffer.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdr_capture_buffer_pkg.sv
// Shared types and constants for the header capture buffer and its parser.
// The header depth here must match the downstream parser's header depth.
package hdr_capture_buffer_pkg;

  localparam int HDR_MAX_LEN = 64;
  localparam int WORD_BYTES  = 4;
  localparam int HDR_LEN_W   = $clog2(HDR_MAX_LEN + 1);

  typedef logic [7:0]           byte_t;
  typedef logic [HDR_LEN_W-1:0] hdr_len_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_DRAIN,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  // A last word advertising 0 or more than a full word of bytes counts as a full word.
  function automatic int unsigned lane_count(input logic last, input logic [2:0] nbytes);
    lane_count = WORD_BYTES;
    if (last && (nbytes != 3'd0) && (nbytes <= 3'd4)) begin
      lane_count = 32'(nbytes);
    end
  endfunction

endpackage

// File: rtl/hdr_byte_writer.sv
// Maps the lanes of one stream word onto header byte positions starting at
// wr_ptr, clipping whatever would fall beyond the end of the header buffer.
module hdr_byte_writer #(
  parameter int HDR_MAX_LEN = 64,
  parameter int WORD_BYTES  = 4,
  parameter int LEN_W       = $clog2(HDR_MAX_LEN + 1)
) (
  input  logic [LEN_W-1:0]              wr_ptr_i,
  input  logic [8*WORD_BYTES-1:0]       s_data_i,
  input  logic                          s_last_i,
  input  logic [2:0]                    s_bytes_i,
  output logic [HDR_MAX_LEN-1:0]        wr_en_o,
  output logic [HDR_MAX_LEN-1:0][7:0]   wr_data_o,
  output logic [LEN_W-1:0]              next_ptr_o,
  output logic                          full_o,
  output logic                          clipped_o
);
  import hdr_capture_buffer_pkg::*;

  localparam int unsigned MAX_U = HDR_MAX_LEN;

  always_comb begin
    int unsigned ptr;
    int unsigned avail;
    int unsigned n_valid;
    int unsigned n_wr;
    int unsigned off;
    logic [1:0]  lane;

    ptr     = 32'(wr_ptr_i);
    n_valid = lane_count(s_last_i, s_bytes_i);
    avail   = (ptr < MAX_U) ? (MAX_U - ptr) : 32'd0;
    n_wr    = (n_valid < avail) ? n_valid : avail;
    off     = 32'd0;
    lane    = 2'd0;

    wr_en_o   = '0;
    wr_data_o = '0;
    for (int i = 0; i < HDR_MAX_LEN; i++) begin
      off = 32'(i) - ptr;
      if ((32'(i) >= ptr) && (off < n_wr)) begin
        lane         = off[1:0];
        wr_en_o[i]   = 1'b1;
        wr_data_o[i] = s_data_i[{~lane, 3'b000} +: 8];
      end
    end

    next_ptr_o = LEN_W'(ptr + n_wr);
    full_o     = ((ptr + n_wr) == MAX_U);
    clipped_o  = (n_valid > n_wr);
  end

endmodule

// File: rtl/hdr_capture_buffer.sv
// Captures the leading bytes of a word stream into a header buffer, launches
// the parser and holds the buffer until it finishes. Optional counters: HDR_CAPTURE_STATS_EN.
module hdr_capture_buffer #(
  parameter int HDR_MAX_LEN = hdr_capture_buffer_pkg::HDR_MAX_LEN,
  parameter int WORD_BYTES  = hdr_capture_buffer_pkg::WORD_BYTES,
  localparam int LEN_W      = $clog2(HDR_MAX_LEN + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [8*WORD_BYTES-1:0]     s_data_i,
  input  logic                        s_valid_i,
  input  logic                        s_last_i,
  input  logic [2:0]                  s_bytes_i,
  output logic                        s_ready_o,
  output logic [HDR_MAX_LEN-1:0][7:0] pkt_hdr_o,
  output logic                        start_o,
  input  logic                        parser_ready_i,
  output logic [LEN_W-1:0]            hdr_len_o,
  output logic                        trunc_o,
`ifdef HDR_CAPTURE_STATS_EN
  output logic [31:0]                 stat_pkts_o,
  output logic [31:0]                 stat_trunc_o,
`endif
  output logic                        busy_o
);
  import hdr_capture_buffer_pkg::*;

  state_t                        state_q, state_d;
  logic [LEN_W-1:0]              wr_ptr_q, wr_ptr_d;
  logic [HDR_MAX_LEN-1:0][7:0]   hdr_q, hdr_d;
  logic [LEN_W-1:0]              hdr_len_q, hdr_len_d;
  logic                          trunc_q, trunc_d;
  logic                          start_q, start_d;
  logic                          busy_seen_q, busy_seen_d;

  logic                          beat;
  logic                          busy_seen_now;
  logic [LEN_W-1:0]              wr_base;
  logic [HDR_MAX_LEN-1:0]        wr_en;
  logic [HDR_MAX_LEN-1:0][7:0]   wr_data;
  logic [LEN_W-1:0]              next_ptr;
  logic                          wr_full;
  logic                          wr_clipped;

  assign s_ready_o     = (state_q == S_IDLE) || (state_q == S_FILL) || (state_q == S_DRAIN);
  assign beat          = s_valid_i & s_ready_o;
  assign busy_seen_now = busy_seen_q | ~parser_ready_i;
  assign wr_base       = (state_q == S_IDLE) ? '0 : wr_ptr_q;

  hdr_byte_writer #(
    .HDR_MAX_LEN (HDR_MAX_LEN),
    .WORD_BYTES  (WORD_BYTES),
    .LEN_W       (LEN_W)
  ) u_writer (
    .wr_ptr_i   (wr_base),
    .s_data_i   (s_data_i),
    .s_last_i   (s_last_i),
    .s_bytes_i  (s_bytes_i),
    .wr_en_o    (wr_en),
    .wr_data_o  (wr_data),
    .next_ptr_o (next_ptr),
    .full_o     (wr_full),
    .clipped_o  (wr_clipped)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      hdr_q       <= '0;
      hdr_len_q   <= '0;
      trunc_q     <= 1'b0;
      start_q     <= 1'b0;
      busy_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      hdr_q       <= hdr_d;
      hdr_len_q   <= hdr_len_d;
      trunc_q     <= trunc_d;
      start_q     <= start_d;
      busy_seen_q <= busy_seen_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    hdr_d       = hdr_q;
    hdr_len_d   = hdr_len_q;
    trunc_d     = trunc_q;
    start_d     = 1'b0;
    busy_seen_d = busy_seen_q;

    case (state_q)
      S_IDLE, S_FILL: begin
        if (beat) begin
          // A new packet wipes the previous header and its status before writing.
          if (state_q == S_IDLE) begin
            hdr_d     = '0;
            hdr_len_d = '0;
            trunc_d   = 1'b0;
          end
          for (int i = 0; i < HDR_MAX_LEN; i++) begin
            if (wr_en[i]) begin
              hdr_d[i] = wr_data[i];
            end
          end
          wr_ptr_d = next_ptr;

          if (s_last_i) begin
            start_d   = 1'b1;
            hdr_len_d = next_ptr;
            trunc_d   = wr_clipped;
            state_d   = S_WAIT_BUSY;
          end else if (wr_full) begin
            start_d     = 1'b1;
            hdr_len_d   = LEN_W'(HDR_MAX_LEN);
            trunc_d     = 1'b1;
            busy_seen_d = 1'b0;
            state_d     = S_DRAIN;
          end else begin
            state_d = S_FILL;
          end
        end
      end

      S_DRAIN: begin
        // The parser may start and even finish while the tail is still draining.
        busy_seen_d = busy_seen_now;
        if (beat && s_last_i) begin
          if (busy_seen_now && parser_ready_i) begin
            state_d = S_IDLE;
          end else if (busy_seen_now) begin
            state_d = S_WAIT_DONE;
          end else begin
            state_d = S_WAIT_BUSY;
          end
        end
      end

      S_WAIT_BUSY: begin
        if (!parser_ready_i) begin
          state_d = S_WAIT_DONE;
        end
      end

      S_WAIT_DONE: begin
        if (parser_ready_i) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign pkt_hdr_o = hdr_q;
  assign hdr_len_o = hdr_len_q;
  assign trunc_o   = trunc_q;
  assign start_o   = start_q;
  assign busy_o    = (state_q != S_IDLE);

`ifdef HDR_CAPTURE_STATS_EN
  logic [31:0] stat_pkts_q;
  logic [31:0] stat_trunc_q;

  // trunc_q is updated on the same edge that raises start_q, so it is valid here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_pkts_q  <= '0;
      stat_trunc_q <= '0;
    end else if (start_q) begin
      stat_pkts_q <= stat_pkts_q + 32'd1;
      if (trunc_q) begin
        stat_trunc_q <= stat_trunc_q + 32'd1;
      end
    end
  end

  assign stat_pkts_o  = stat_pkts_q;
  assign stat_trunc_o = stat_trunc_q;
`endif

endmodule

// File: tb/tb_hdr_capture_buffer.sv
// Self-checking bench for hdr_capture_buffer: random packets against a byte-level
// model of the captured header, with a behavioural parser driving parser_ready_i.
module tb_hdr_capture_buffer;

  localparam int HDR_MAX_LEN = 64;
  localparam int LEN_W       = $clog2(HDR_MAX_LEN + 1);

  logic                        clk = 1'b0;
  logic                        rst;
  logic [31:0]                 s_data_i;
  logic                        s_valid_i;
  logic                        s_last_i;
  logic [2:0]                  s_bytes_i;
  logic                        s_ready_o;
  logic [HDR_MAX_LEN-1:0][7:0] pkt_hdr_o;
  logic                        start_o;
  logic                        parser_ready_i;
  logic [LEN_W-1:0]            hdr_len_o;
  logic                        trunc_o;
  logic                        busy_o;
`ifdef HDR_CAPTURE_STATS_EN
  logic [31:0]                 stat_pkts_o;
  logic [31:0]                 stat_trunc_o;
`endif

  int errors = 0;
  int checks = 0;
  int startCount = 0;
  bit parserAuto = 1'b1;
  bit manualReady = 1'b1;
  int parserLat = 0;
  int expPkts = 0;
  int expTrunc = 0;
  logic [7:0] pktBytes [256];
  logic [HDR_MAX_LEN-1:0][7:0] expHdr;

  always #5 clk = ~clk;

  hdr_capture_buffer dut (
    .clk            (clk),
    .rst            (rst),
    .s_data_i       (s_data_i),
    .s_valid_i      (s_valid_i),
    .s_last_i       (s_last_i),
    .s_bytes_i      (s_bytes_i),
    .s_ready_o      (s_ready_o),
    .pkt_hdr_o      (pkt_hdr_o),
    .start_o        (start_o),
    .parser_ready_i (parser_ready_i),
    .hdr_len_o      (hdr_len_o),
    .trunc_o        (trunc_o),
`ifdef HDR_CAPTURE_STATS_EN
    .stat_pkts_o    (stat_pkts_o),
    .stat_trunc_o   (stat_trunc_o),
`endif
    .busy_o         (busy_o)
  );

  // Count start pulses, sampled just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (start_o === 1'b1) startCount++;
    end
  end

  // Behavioural parser: ready is a held level that drops after start and rises after a latency.
  initial begin
    int cnt;
    int lat;
    bit pend;
    cnt = 0;
    lat = 1;
    pend = 1'b0;
    parser_ready_i = 1'b1;
    forever begin
      @(negedge clk);
      if (!parserAuto) begin
        parser_ready_i = manualReady;
        cnt = 0;
        pend = 1'b0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) parser_ready_i = 1'b1;
        end else if (pend) begin
          parser_ready_i = 1'b0;
          cnt = lat;
          pend = 1'b0;
        end
        if (start_o === 1'b1) begin
          pend = 1'b1;
          lat = (parserLat > 0) ? parserLat : int'($urandom_range(1, 8));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic fill_bytes();
    for (int i = 0; i < 256; i++) pktBytes[i] = 8'($urandom);
  endtask

  // Called at a falling edge; returns at the falling edge after the beat transferred.
  task automatic drive_word(input logic [31:0] d, input logic last, input logic [2:0] nb, output bit ok);
    int cyc;
    s_data_i  = d;
    s_last_i  = last;
    s_bytes_i = nb;
    s_valid_i = 1'b1;
    cyc = 0;
    while (s_ready_o !== 1'b1 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc >= 400) begin
      errors++;
      $display("[TB] FAIL handshake_timeout: s_ready_o=%b required 1", s_ready_o);
      s_valid_i = 1'b0;
      ok = 1'b0;
      return;
    end
    @(negedge clk);
    s_valid_i = 1'b0;
    ok = 1'b1;
  endtask

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    while (busy_o !== 1'b0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_timeout: busy_o=%b required 0", busy_o);
    end
    checks++;
    if (s_ready_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL idle_ready: s_ready_o=%b required 1", s_ready_o);
    end
  endtask

  task automatic send_packet(input int len, input bit gaps, input bit waitDone);
    int words, nv, s0, complBeat, effLen, pick;
    logic [31:0] w;
    logic [2:0] nb;
    bit lastw, ok;
    words  = (len + 3) / 4;
    s0     = startCount;
    effLen = (len < HDR_MAX_LEN) ? len : HDR_MAX_LEN;
    for (int i = 0; i < HDR_MAX_LEN; i++) expHdr[i] = (i < len) ? pktBytes[i] : 8'h00;
    complBeat = (len > HDR_MAX_LEN) ? (HDR_MAX_LEN / 4 - 1) : (words - 1);
    for (int wi = 0; wi < words; wi++) begin
      nv = (wi == words - 1) ? (len - 4 * wi) : 4;
      for (int k = 0; k < 4; k++) begin
        if (k < nv) w[31-8*k -: 8] = pktBytes[4*wi+k];
        else        w[31-8*k -: 8] = 8'($urandom);
      end
      lastw = (wi == words - 1);
      if (lastw && nv == 4) begin
        pick = int'($urandom_range(0, 4));
        nb = (pick == 0) ? 3'd0 : (pick == 1) ? 3'd4 : 3'(pick + 3);
      end else if (lastw) begin
        nb = 3'(nv);
      end else begin
        nb = 3'($urandom);
      end
      if (gaps) begin
        s_valid_i = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      drive_word(w, lastw, nb, ok);
      if (!ok) return;
      if (wi == complBeat) begin
        checks++;
        if (start_o !== 1'b1) begin
          errors++;
          $display("[TB] FAIL start_pulse len=%0d: start_o=%b required 1", len, start_o);
        end
        checks++;
        if (pkt_hdr_o !== expHdr) begin
          errors++;
          $display("[TB] FAIL header len=%0d: got %h required %h", len, pkt_hdr_o, expHdr);
        end
        checks++;
        if (hdr_len_o !== LEN_W'(effLen)) begin
          errors++;
          $display("[TB] FAIL hdr_len len=%0d: got %0d required %0d", len, hdr_len_o, effLen);
        end
        checks++;
        if (trunc_o !== (len > HDR_MAX_LEN)) begin
          errors++;
          $display("[TB] FAIL trunc len=%0d: got %b required %b", len, trunc_o, len > HDR_MAX_LEN);
        end
      end else begin
        checks++;
        if (start_o !== 1'b0) begin
          errors++;
          $display("[TB] FAIL start_spurious len=%0d beat=%0d: start_o=%b required 0", len, wi, start_o);
        end
      end
    end
    s_last_i = 1'b0;
    if (len > HDR_MAX_LEN) begin
      checks++;
      if (pkt_hdr_o !== expHdr) begin
        errors++;
        $display("[TB] FAIL drain_hold: got %h required %h", pkt_hdr_o, expHdr);
      end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (startCount - s0 != 1) begin
      errors++;
      $display("[TB] FAIL start_count len=%0d: got %0d pulses required 1", len, startCount - s0);
    end
    expPkts++;
    if (len > HDR_MAX_LEN) expTrunc++;
    if (waitDone) begin
      wait_idle();
      checks++;
      if (pkt_hdr_o !== expHdr || hdr_len_o !== LEN_W'(effLen)) begin
        errors++;
        $display("[TB] FAIL idle_hold len=%0d: hdr_len=%0d required %0d", len, hdr_len_o, effLen);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_valid_i = 1'b0;
    s_last_i = 1'b0;
    s_bytes_i = 3'd0;
    s_data_i = '0;
    #2;
    checks++;
    if (pkt_hdr_o !== '0 || hdr_len_o !== '0 || trunc_o !== 1'b0 || start_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: len=%0d trunc=%b start=%b required all 0", hdr_len_o, trunc_o, start_o);
    end
    checks++;
    if (s_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_handshake: ready=%b busy=%b required 1/0", s_ready_o, busy_o);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fixed_len(input int len);
    fill_bytes();
    send_packet(len, 1'b1, 1'b1);
  endtask

  task automatic test_truncated();
    parserLat = 20;
    fill_bytes();
    send_packet(100, 1'b0, 1'b0);
    checks++;
    if (s_ready_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL trunc_blocked: ready=%b busy=%b required 0/1", s_ready_o, busy_o);
    end
    wait_idle();
    parserLat = 0;
  endtask

  task automatic test_back_to_back();
    int base, cyc;
    manualReady = 1'b1;
    parserAuto = 1'b0;
    repeat (2) @(negedge clk);
    fill_bytes();
    send_packet(20, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    checks++;
    if (busy_o !== 1'b1 || s_ready_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wait_busy_hold: busy=%b ready=%b required 1/0", busy_o, s_ready_o);
    end
    fill_bytes();
    base = startCount;
    fork
      send_packet(7, 1'b0, 1'b1);
      begin
        repeat (4) @(negedge clk);
        checks++;
        if (s_ready_o !== 1'b0) begin
          errors++;
          $display("[TB] FAIL b2b_blocked_busy: s_ready_o=%b required 0", s_ready_o);
        end
        manualReady = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (s_ready_o !== 1'b0) begin
          errors++;
          $display("[TB] FAIL b2b_blocked_done: s_ready_o=%b required 0", s_ready_o);
        end
        manualReady = 1'b1;
        cyc = 0;
        while (startCount == base && cyc < 50) begin
          @(negedge clk);
          cyc++;
        end
        checks++;
        if (startCount != base + 1) begin
          errors++;
          $display("[TB] FAIL b2b_second_start: got %0d pulses required 1", startCount - base);
        end
        @(negedge clk);
        manualReady = 1'b0;
        repeat (3) @(negedge clk);
        manualReady = 1'b1;
      end
    join
    repeat (2) @(negedge clk);
    parserAuto = 1'b1;
  endtask

  task automatic test_async_reset();
    bit ok;
    logic [31:0] w;
    fill_bytes();
    for (int wi = 0; wi < 3; wi++) begin
      w = {pktBytes[4*wi], pktBytes[4*wi+1], pktBytes[4*wi+2], pktBytes[4*wi+3]};
      drive_word(w, 1'b0, 3'd4, ok);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (pkt_hdr_o !== '0 || hdr_len_o !== '0 || trunc_o !== 1'b0 || start_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset_outputs: len=%0d trunc=%b start=%b required all 0", hdr_len_o, trunc_o, start_o);
    end
    checks++;
    if (s_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset_handshake: ready=%b busy=%b required 1/0", s_ready_o, busy_o);
    end
    @(negedge clk);
    rst = 1'b0;
    expPkts = 0;
    expTrunc = 0;
    @(negedge clk);
    fill_bytes();
    send_packet(37, 1'b1, 1'b1);
  endtask

`ifdef HDR_CAPTURE_STATS_EN
  task automatic test_stats();
    fill_bytes();
    send_packet(20, 1'b1, 1'b1);
    fill_bytes();
    send_packet(100, 1'b1, 1'b1);
    fill_bytes();
    send_packet(48, 1'b1, 1'b1);
    checks++;
    if (stat_pkts_o !== 32'(expPkts)) begin
      errors++;
      $display("[TB] FAIL stat_pkts: got %0d required %0d", stat_pkts_o, expPkts);
    end
    checks++;
    if (stat_trunc_o !== 32'(expTrunc)) begin
      errors++;
      $display("[TB] FAIL stat_trunc: got %0d required %0d", stat_trunc_o, expTrunc);
    end
  endtask
`endif

  task automatic test_random();
    for (int p = 0; p < 10; p++) begin
      fill_bytes();
      send_packet(int'($urandom_range(1, 130)), 1'b1, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_fixed_len(60);
    test_fixed_len(14);
    test_fixed_len(1);
    test_fixed_len(64);
    test_truncated();
    test_back_to_back();
    test_async_reset();
`ifdef HDR_CAPTURE_STATS_EN
    test_stats();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
